// File: rtl/terrain_pkg.sv
// Shared terrain geometry, scheduler state encoding and column data type
// used by the crater carving logic.
package terrain_pkg;

    localparam int NUM_COLS = 640;
    localparam int NUM_ROWS = 480;
    localparam int RADIUS_W = 5;
    localparam int COL_W    = 10;
    localparam int ROW_W    = 9;

    // One past the last valid column, sized for the signed column arithmetic.
    localparam logic [COL_W:0] COL_END = (COL_W+1)'(NUM_COLS);

    typedef logic [NUM_ROWS-1:0] column_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/crater_scheduler_if.sv
// Terrain column memory port shared between the crater scheduler (master)
// and the terrain store (slave).
interface crater_scheduler_if;
    import terrain_pkg::*;

    logic             own_rd;
    logic [COL_W-1:0] mem_rd_addr;
    column_t          mem_rd_data;
    logic             mem_we;
    logic [COL_W-1:0] mem_wr_addr;
    column_t          mem_wr_data;

    modport master (
        output own_rd, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  own_rd, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/crater_mask.sv
// Row mask for one crater column: bits lo..hi set, where the span cy-h..cy+h
// is clipped to the screen so a crater near an edge never wraps.
module crater_mask
    import terrain_pkg::*;
(
    input  logic [ROW_W-1:0]  cy_i,
    input  logic [RADIUS_W:0] h_i,
    output column_t           mask_o
);

    localparam int SPAN_W = ROW_W + 1;
    localparam logic [SPAN_W-1:0] ROW_MAX = SPAN_W'(NUM_ROWS - 1);

    logic [SPAN_W-1:0] cy_ext;
    logic [SPAN_W-1:0] h_ext;
    logic [SPAN_W-1:0] lo;
    logic [SPAN_W-1:0] hi_raw;
    logic [SPAN_W-1:0] hi;

    assign cy_ext = SPAN_W'(cy_i);
    assign h_ext  = SPAN_W'(h_i);

    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
        mask_o = '0;
        lo     = (cy_ext >= h_ext) ? (cy_ext - h_ext) : '0;
        hi_raw = cy_ext + h_ext;
        hi     = (hi_raw > ROW_MAX) ? ROW_MAX : hi_raw;
        for (int i = 0; i < NUM_ROWS; i++) begin
            mask_o[i] = (SPAN_W'(i) >= lo) && (SPAN_W'(i) <= hi);
        end
    end

endmodule

// File: rtl/crater_scheduler.sv
// Round-robin crater carver: walks each column of a circle, computes its
// half-height, and read-modify-writes the terrain column during vblank.
module crater_scheduler
    import terrain_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vblank,
    input  logic [1:0]          req,
    input  logic [COL_W-1:0]    cx0,
    input  logic [COL_W-1:0]    cx1,
    input  logic [ROW_W-1:0]    cy0,
    input  logic [ROW_W-1:0]    cy1,
    input  logic [RADIUS_W-1:0] r0,
    input  logic [RADIUS_W-1:0] r1,
    output logic [1:0]          done,
    output logic                busy,
    crater_scheduler_if.master  mem
);

    localparam int H_W    = RADIUS_W + 1;
    localparam int SQ_W   = 2 * RADIUS_W;
    localparam int HSQ_W  = 2 * H_W;
    localparam int X_W    = COL_W + 2;

    state_e                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      last_q, last_d;
    logic [COL_W-1:0]          cx_q, cx_d;
    logic [ROW_W-1:0]          cy_q, cy_d;
    logic [RADIUS_W-1:0]       r_q, r_d;
    logic signed [RADIUS_W:0]  dx_q, dx_d;
    logic [H_W-1:0]            h_q, h_d;

    logic [1:0]                done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      own_rd_q, own_rd_d;
    logic [COL_W-1:0]          rd_addr_q, rd_addr_d;
    logic                      we_q, we_d;
    logic [COL_W-1:0]          wr_addr_q, wr_addr_d;
    column_t                   wr_data_q, wr_data_d;

    logic                      grant_sel;
    logic [RADIUS_W-1:0]       r_sel;
    logic [RADIUS_W-1:0]       dx_mag;
    logic [SQ_W-1:0]           r_sq;
    logic [SQ_W-1:0]           dx_sq;
    logic [SQ_W-1:0]           rem;
    logic [H_W-1:0]            h_inc;
    logic [HSQ_W-1:0]          h_inc_sq;
    logic [X_W-1:0]            x_sum;
    logic                      x_in_range;
    column_t                   mask;

    // Remaining vertical budget for this column: rem = r^2 - dx^2, never negative.
    assign dx_mag   = dx_q[RADIUS_W] ? RADIUS_W'(-dx_q) : dx_q[RADIUS_W-1:0];
    assign r_sq     = SQ_W'(r_q) * SQ_W'(r_q);
    assign dx_sq    = SQ_W'(dx_mag) * SQ_W'(dx_mag);
    assign rem      = r_sq - dx_sq;
    assign h_inc    = h_q + H_W'(1);
    assign h_inc_sq = HSQ_W'(h_inc) * HSQ_W'(h_inc);

    assign x_sum      = X_W'(cx_q) + {{(X_W-H_W){dx_q[RADIUS_W]}}, dx_q};
    assign x_in_range = !x_sum[X_W-1] && (x_sum[COL_W:0] < COL_END);

    always_comb begin
        unique case (req)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_q;
            default: grant_sel = 1'b0;
        endcase
    end

    assign r_sel = grant_sel ? r1 : r0;

    crater_mask u_mask (
        .cy_i   (cy_q),
        .h_i    (h_q),
        .mask_o (mask)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        dx_d    = dx_q;
        h_d     = h_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = grant_sel;
                    cx_d    = grant_sel ? cx1 : cx0;
                    cy_d    = grant_sel ? cy1 : cy0;
                    r_d     = r_sel;
                    dx_d    = -$signed({1'b0, r_sel});
                    h_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Outside vblank an in-range column parks here with h frozen.
                if (HSQ_W'(rem) >= h_inc_sq) begin
                    h_d = h_inc;
                end else if (!x_in_range) begin
                    state_d = S_NEXT;
                end else if (vblank) begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (dx_q == $signed({1'b0, r_q})) begin
                    state_d = S_DONE;
                end else begin
                    dx_d    = dx_q + H_W'(1);
                    h_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        own_rd_d  = (state_d == S_READ) || (state_d == S_WAIT);
        rd_addr_d = (state_d == S_READ) ? x_sum[COL_W-1:0] : rd_addr_q;
        we_d      = (state_d == S_WRITE);
        wr_addr_d = (state_d == S_WRITE) ? rd_addr_q : wr_addr_q;
        wr_data_d = (state_d == S_WRITE) ? (mem.mem_rd_data & ~mask) : wr_data_q;
        done_d    = (state_d == S_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cx_q      <= '0;
            cy_q      <= '0;
            r_q       <= '0;
            dx_q      <= '0;
            h_q       <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            own_rd_q  <= 1'b0;
            rd_addr_q <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            r_q       <= r_d;
            dx_q      <= dx_d;
            h_q       <= h_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            own_rd_q  <= own_rd_d;
            rd_addr_q <= rd_addr_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign done            = done_q;
    assign busy            = busy_q;
    assign mem.own_rd      = own_rd_q;
    assign mem.mem_rd_addr = rd_addr_q;
    assign mem.mem_we      = we_q;
    assign mem.mem_wr_addr = wr_addr_q;
    assign mem.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_crater_scheduler.sv
// Directed bench for crater_scheduler against a terrain memory model and an
// independent circle-carving reference.
module tb_crater_scheduler;
    import terrain_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                vblank;
    logic [1:0]          req;
    logic [COL_W-1:0]    cx0, cx1;
    logic [ROW_W-1:0]    cy0, cy1;
    logic [RADIUS_W-1:0] r0, r1;
    logic [1:0]          done;
    logic                busy;
    logic                fill = 1'b0;

    crater_scheduler_if mem_if ();

    crater_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vblank  (vblank),
        .req     (req),
        .cx0     (cx0),
        .cx1     (cx1),
        .cy0     (cy0),
        .cy1     (cy1),
        .r0      (r0),
        .r1      (r1),
        .done    (done),
        .busy    (busy),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;

    column_t          mem   [NUM_COLS];
    column_t          model [NUM_COLS];
    int               wr_count = 0;
    int               addr_err = 0;
    logic [COL_W-1:0] rd_hist1 = '0;
    logic [COL_W-1:0] rd_hist2 = '0;

    // Terrain store: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        if (fill) begin
            for (int c = 0; c < NUM_COLS; c++) mem[c] <= '1;
        end else if (mem_if.mem_we) begin
            if (int'(mem_if.mem_wr_addr) < NUM_COLS) mem[mem_if.mem_wr_addr] <= mem_if.mem_wr_data;
            else addr_err <= addr_err + 1;
            if (mem_if.mem_wr_addr != rd_hist2) addr_err <= addr_err + 1;
            wr_count <= wr_count + 1;
        end
        mem_if.mem_rd_data <= (int'(mem_if.mem_rd_addr) < NUM_COLS) ? mem[mem_if.mem_rd_addr] : '0;
        rd_hist1 <= mem_if.mem_rd_addr;
        rd_hist2 <= rd_hist1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_terrain();
        fill = 1'b1;
        tick(1);
        fill = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) model[c] = '1;
    endtask

    task automatic model_carve(input int cx, input int cy, input int r, input int dlo, input int dhi);
        for (int dx = dlo; dx <= dhi; dx++) begin
            int x, rem, h;
            x = cx + dx;
            if (x < 0 || x >= NUM_COLS) continue;
            rem = r * r - dx * dx;
            h = 0;
            while ((h + 1) * (h + 1) <= rem) h++;
            for (int y = cy - h; y <= cy + h; y++)
                if (y >= 0 && y < NUM_ROWS) model[x][y] = 1'b0;
        end
    endtask

    function automatic int col_diff();
        int n = 0;
        for (int c = 0; c < NUM_COLS; c++) if (mem[c] !== model[c]) n++;
        return n;
    endfunction

    task automatic set_params(input int p, input int cx, input int cy, input int r);
        if (p == 0) begin cx0 = COL_W'(cx); cy0 = ROW_W'(cy); r0 = RADIUS_W'(r); end
        else        begin cx1 = COL_W'(cx); cy1 = ROW_W'(cy); r1 = RADIUS_W'(r); end
    endtask

    task automatic wait_done(input int p, input bit scramble, input int max_cyc,
                             output logic [1:0] d, output int busy_cyc);
        d = '0;
        busy_cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (scramble && busy_cyc == 1) set_params(p, 50, 60, 31);
            if (done != 2'b00) begin
                d = done;
                break;
            end
        end
    endtask

    typedef struct {
        int p;
        int cx;
        int cy;
        int r;
        int n_wr;
        int busy_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [1:0] d;
        int         bc;
        int         wr0;

        vecs[0] = '{0, 320, 240, 3, 7, 47};
        vecs[1] = '{1,   1,   2, 4, 6, 57};
        vecs[2] = '{0, 639, 479, 0, 1,  6};
        vecs[3] = '{1, 638, 478, 5, 7, 79};
        vecs[4] = '{0,   0,   0, 1, 2, 14};

        reset_n = 1'b0;
        vblank  = 1'b1;
        req     = 2'b00;
        set_params(0, 0, 0, 0);
        set_params(1, 0, 0, 0);
        fill_terrain();
        tick(2);
        check("rst_done",    done, 0);
        check("rst_busy",    busy, 0);
        check("rst_own_rd",  mem_if.own_rd, 0);
        check("rst_we",      mem_if.mem_we, 0);
        check("rst_rd_addr", mem_if.mem_rd_addr, 0);
        check("rst_wr_addr", mem_if.mem_wr_addr, 0);
        check("rst_wr_data", mem_if.mem_wr_data == '0, 1);
        reset_n = 1'b1;
        tick(1);

        for (int i = 0; i < 5; i++) begin
            wr0 = wr_count;
            set_params(vecs[i].p, vecs[i].cx, vecs[i].cy, vecs[i].r);
            req[vecs[i].p] = 1'b1;
            wait_done(vecs[i].p, 1'b1, 400, d, bc);
            req[vecs[i].p] = 1'b0;
            check($sformatf("v%0d_done", i), d, 2'b01 << vecs[i].p);
            check($sformatf("v%0d_cycles", i), bc, vecs[i].busy_cyc);
            tick(1);
            check($sformatf("v%0d_done_once", i), done, 0);
            check($sformatf("v%0d_writes", i), wr_count - wr0, vecs[i].n_wr);
            model_carve(vecs[i].cx, vecs[i].cy, vecs[i].r, -vecs[i].r, vecs[i].r);
            check($sformatf("v%0d_terrain", i), col_diff(), 0);
            case (i)
                0: begin
                    check("c320_rows", mem[320][244:236], 9'h101);
                    check("c317_rows", mem[317][241:239], 3'b101);
                end
                1: begin
                    check("c1_rows", mem[1][7:0], 8'h80);
                    check("c1_top",  mem[1][479], 1);
                    check("c0_rows", mem[0][7:0], 8'hC0);
                end
                2: begin
                    check("c639_bit",  mem[639][479], 0);
                    check("c639_rest", &mem[639][478:0], 1);
                end
                default: ;
            endcase
        end

        // Round-robin: tie after reset favours P1, then P2 after a P1-only grant.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        set_params(0, 100, 100, 2);
        set_params(1, 200, 200, 2);
        req = 2'b11;
        wait_done(0, 1'b0, 400, d, bc);
        req[0] = 1'b0;
        check("tie1_first", d, 2'b01);
        wait_done(1, 1'b0, 400, d, bc);
        req[1] = 1'b0;
        check("tie1_second", d, 2'b10);
        set_params(0, 300, 100, 1);
        req = 2'b01;
        wait_done(0, 1'b0, 400, d, bc);
        req[0] = 1'b0;
        check("solo_p1", d, 2'b01);
        set_params(0, 400, 50, 1);
        set_params(1, 500, 50, 1);
        req = 2'b11;
        wait_done(1, 1'b0, 400, d, bc);
        req[1] = 1'b0;
        check("tie2_first", d, 2'b10);
        wait_done(0, 1'b0, 400, d, bc);
        req[0] = 1'b0;
        check("tie2_second", d, 2'b01);
        model_carve(100, 100, 2, -2, 2);
        model_carve(200, 200, 2, -2, 2);
        model_carve(300, 100, 1, -1, 1);
        model_carve(400, 50, 1, -1, 1);
        model_carve(500, 50, 1, -1, 1);
        check("rr_terrain", col_diff(), 0);

        // vblank falls during the second column's read.
        begin
            int   reads = 0;
            int   after = 0;
            bit   dropped = 1'b0;
            logic prev = 1'b0;
            fill_terrain();
            wr0 = wr_count;
            set_params(0, 100, 100, 3);
            req = 2'b01;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (mem_if.own_rd && !prev) reads++;
                prev = mem_if.own_rd;
                if (dropped) begin
                    after++;
                    if (after == 20) break;
                end else if (reads == 2) begin
                    vblank  = 1'b0;
                    dropped = 1'b1;
                end
            end
            check("vb_reads_held", reads, 2);
            check("vb_write_kept", wr_count - wr0, 2);
            check("vb_busy", busy, 1);
            vblank = 1'b1;
            wait_done(0, 1'b0, 400, d, bc);
            req = 2'b00;
            check("vb_done", d, 2'b01);
            check("vb_writes", wr_count - wr0, 7);
            model_carve(100, 100, 3, -3, 3);
            check("vb_terrain", col_diff(), 0);
        end

        // Reset while the third column is in CALC.
        begin
            int we_seen = 0;
            fill_terrain();
            tick(1);
            wr0 = wr_count;
            set_params(0, 200, 50, 3);
            req = 2'b01;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (mem_if.mem_we) we_seen++;
                if (we_seen == 2) break;
            end
            check("mid_writes_seen", we_seen, 2);
            tick(2);
            reset_n = 1'b0;
            req = 2'b00;
            tick(1);
            check("mid_busy",   busy, 0);
            check("mid_we",     mem_if.mem_we, 0);
            check("mid_own_rd", mem_if.own_rd, 0);
            check("mid_done",   done, 0);
            check("mid_rd_addr", mem_if.mem_rd_addr, 0);
            reset_n = 1'b1;
            tick(20);
            check("mid_no_more_writes", wr_count - wr0, 2);
            check("mid_idle", busy, 0);
            model_carve(200, 50, 3, -3, -2);
            check("mid_terrain", col_diff(), 0);
        end

        check("wr_addr_pipe", addr_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
